// File: rtl/ll_req_arbiter.sv
// Round-robin arbiter sharing one linked-list request/response front end
// between NUM_REQ requesters. Exactly one request is in flight at a time; the
// response is routed back to the granted requester only. A watchdog
// synthesizes an error response if the downstream side goes silent.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ARB       | idle, picking the next winner from rr_ptr upward
// ISSUE     | request pulse on req_vld / rq_ack is on the outputs
// WAIT_RESP | waiting for resp_vld, watchdog counting
// DELIVER   | buffered response presented on rs_*, waiting for rs_taken
module ll_req_arbiter #(
   parameter int                  NUM_REQ       = 4,
   parameter int                  PTR_WD        = 8,
   parameter int                  DATA_WD       = 32,
   parameter int                  TYPE_WD       = 4,
   parameter int                  TIMEOUT_CYC   = 1024,
   parameter logic [TYPE_WD-1:0]  ERR_RESP_TYPE = 4'd0,
   parameter logic [DATA_WD-1:0]  TIMEOUT_CODE  = 32'hDEAD_0001
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [NUM_REQ-1:0]          rq_vld,
   input  logic [NUM_REQ*TYPE_WD-1:0]  rq_type,
   input  logic [NUM_REQ*PTR_WD-1:0]   rq_pos,
   input  logic [NUM_REQ*DATA_WD-1:0]  rq_data,
   output logic [NUM_REQ-1:0]          rq_ack,
   output logic [NUM_REQ-1:0]          rs_vld,
   output logic [TYPE_WD-1:0]          rs_type,
   output logic [DATA_WD-1:0]          rs_data,
   output logic                        rs_data_vld,
   input  logic [NUM_REQ-1:0]          rs_taken,
   input  logic                        intf_ready,
   output logic                        req_vld,
   output logic [TYPE_WD-1:0]          req_type,
   output logic [PTR_WD-1:0]           req_pos,
   output logic [DATA_WD-1:0]          req_data,
   input  logic                        resp_vld,
   input  logic [TYPE_WD-1:0]          resp_type,
   input  logic [DATA_WD-1:0]          resp_data,
   input  logic                        resp_data_vld,
   output logic                        resp_taken,
   output logic                        busy,
   output logic                        timeout_err
);

   localparam int ID_WD = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {ARB, ISSUE, WAIT_RESP, DELIVER} state_t;

   state_t              state, state_nx;
   logic [ID_WD-1:0]    rr_ptr, gnt_id, win_id;
   logic                win_found;
   logic [TYPE_WD-1:0]  win_type;
   logic [PTR_WD-1:0]   win_pos;
   logic [DATA_WD-1:0]  win_data;
   logic [31:0]         tmo_cnt;
   logic                expire, grant, take;

   // Rotating priority search: first requester at or above rr_ptr, wrapping.
   always_comb begin
      int               idx;
      logic [ID_WD-1:0] cand;
      win_id    = '0;
      win_found = 1'b0;
      idx       = 0;
      cand      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         cand = ID_WD'(idx);
         if (!win_found && rq_vld[cand]) begin
            win_id    = cand;
            win_found = 1'b1;
         end
      end
   end

   // Select the winner's request fields with constant slices only.
   always_comb begin
      win_type = '0;
      win_pos  = '0;
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_id == ID_WD'(i)) begin
            win_type = rq_type[i*TYPE_WD +: TYPE_WD];
            win_pos  = rq_pos[i*PTR_WD +: PTR_WD];
            win_data = rq_data[i*DATA_WD +: DATA_WD];
         end
      end
   end

   assign grant  = intf_ready && win_found;
   assign take   = rs_taken[gnt_id];
   assign expire = (TIMEOUT_CYC != 0) && (tmo_cnt == 32'(TIMEOUT_CYC - 1));

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ARB;
      else          state <= state_nx;
   end

   // Next-state logic; a real response beats a same-cycle watchdog expiry.
   always_comb begin
      state_nx = state;
      case (state)
         ARB:       if (grant) state_nx = ISSUE;
         ISSUE:     state_nx = WAIT_RESP;
         WAIT_RESP: if (resp_vld || expire) state_nx = DELIVER;
         DELIVER:   if (take) state_nx = ARB;
         default:   state_nx = ARB;
      endcase
   end

   // Registered outputs, grant bookkeeping, response buffer and watchdog.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rq_ack      <= '0;
         rs_vld      <= '0;
         rs_type     <= '0;
         rs_data     <= '0;
         rs_data_vld <= 1'b0;
         req_vld     <= 1'b0;
         req_type    <= '0;
         req_pos     <= '0;
         req_data    <= '0;
         resp_taken  <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         rr_ptr      <= '0;
         gnt_id      <= '0;
         tmo_cnt     <= '0;
      end else begin
         rq_ack     <= '0;
         req_vld    <= 1'b0;
         resp_taken <= 1'b0;
         busy       <= (state_nx != ARB);
         case (state)
            ARB: begin
               if (grant) begin
                  req_vld  <= 1'b1;
                  rq_ack   <= ONE_HOT0 << win_id;
                  req_type <= win_type;
                  req_pos  <= win_pos;
                  req_data <= win_data;
                  gnt_id   <= win_id;
               end
            end
            WAIT_RESP: begin
               if (resp_vld) begin
                  rs_type     <= resp_type;
                  rs_data     <= resp_data;
                  rs_data_vld <= resp_data_vld;
                  resp_taken  <= 1'b1;
                  rs_vld      <= ONE_HOT0 << gnt_id;
                  tmo_cnt     <= '0;
               end else if (expire) begin
                  rs_type     <= ERR_RESP_TYPE;
                  rs_data     <= TIMEOUT_CODE;
                  rs_data_vld <= 1'b1;
                  timeout_err <= 1'b1;
                  rs_vld      <= ONE_HOT0 << gnt_id;
                  tmo_cnt     <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + 32'd1;
               end
            end
            DELIVER: begin
               if (take) begin
                  rs_vld <= '0;
                  rr_ptr <= (gnt_id == ID_WD'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ll_req_arbiter.sv
// Directed bench for ll_req_arbiter: grant order, latency, watchdog,
// slow consumer and asynchronous reset.
module tb_ll_req_arbiter;

   localparam int N  = 4;
   localparam int PW = 8;
   localparam int DW = 32;
   localparam int TW = 4;

   logic            clk, reset_n;
   logic [N-1:0]    rq_vld, rq_ack, rs_vld, rs_taken;
   logic [N*TW-1:0] rq_type;
   logic [N*PW-1:0] rq_pos;
   logic [N*DW-1:0] rq_data;
   logic [TW-1:0]   rs_type, req_type, resp_type;
   logic [DW-1:0]   rs_data, req_data, resp_data;
   logic [PW-1:0]   req_pos;
   logic            rs_data_vld, intf_ready, req_vld, resp_vld, resp_data_vld;
   logic            resp_taken, busy, timeout_err;

   int errors = 0;
   int checks = 0;

   ll_req_arbiter #(
      .NUM_REQ(N), .PTR_WD(PW), .DATA_WD(DW), .TYPE_WD(TW), .TIMEOUT_CYC(16),
      .ERR_RESP_TYPE(4'd0), .TIMEOUT_CODE(32'hDEAD_0001)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .rq_vld(rq_vld), .rq_type(rq_type), .rq_pos(rq_pos), .rq_data(rq_data),
      .rq_ack(rq_ack), .rs_vld(rs_vld), .rs_type(rs_type), .rs_data(rs_data),
      .rs_data_vld(rs_data_vld), .rs_taken(rs_taken), .intf_ready(intf_ready),
      .req_vld(req_vld), .req_type(req_type), .req_pos(req_pos), .req_data(req_data),
      .resp_vld(resp_vld), .resp_type(resp_type), .resp_data(resp_data),
      .resp_data_vld(resp_data_vld), .resp_taken(resp_taken), .busy(busy),
      .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic set_rq(input int i, input logic [TW-1:0] t, input logic [PW-1:0] p,
                         input logic [DW-1:0] d);
      rq_type[i*TW +: TW] = t;
      rq_pos[i*PW +: PW]  = p;
      rq_data[i*DW +: DW] = d;
   endtask

   // Returns at the negedge where an ack is visible, or after the budget.
   task automatic wait_ack(output logic got);
      got = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (rq_ack != '0) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   // Called in WAIT_RESP; returns at the negedge where rs_vld is visible.
   task automatic give_resp(input logic [TW-1:0] t, input logic [DW-1:0] d, input logic dv);
      resp_vld = 1'b1; resp_type = t; resp_data = d; resp_data_vld = dv;
      @(negedge clk);
      resp_vld = 1'b0; resp_type = '0; resp_data = '0; resp_data_vld = 1'b0;
   endtask

   task automatic take(input int id);
      rs_taken = 4'b0001 << id;
      @(negedge clk);
      rs_taken = '0;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      rq_vld  = 4'b1111;
      repeat (2) @(negedge clk);
      checks++; if (rq_ack !== 4'b0000 || req_vld !== 1'b0) begin errors++;
         $display("FAIL reset_ack: rq_ack=%b req_vld=%b want 0", rq_ack, req_vld); end
      checks++; if (rs_vld !== 4'b0000 || rs_data !== 32'h0 || rs_type !== 4'h0) begin errors++;
         $display("FAIL reset_rs: rs_vld=%b rs_data=%h rs_type=%h want 0", rs_vld, rs_data, rs_type); end
      checks++; if (busy !== 1'b0 || timeout_err !== 1'b0 || resp_taken !== 1'b0 || req_data !== 32'h0) begin errors++;
         $display("FAIL reset_misc: busy=%b terr=%b rtaken=%b req_data=%h want 0", busy, timeout_err, resp_taken, req_data); end
      rq_vld  = '0;
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single;
      logic got;
      set_rq(2, 4'd3, 8'd5, 32'hA5);
      rq_vld = 4'b0100;
      @(negedge clk);
      checks++; if (rq_ack !== 4'b0100 || req_vld !== 1'b1) begin errors++;
         $display("FAIL single_grant: rq_ack=%b req_vld=%b want 0100/1", rq_ack, req_vld); end
      checks++; if (req_pos !== 8'd5 || req_data !== 32'hA5 || req_type !== 4'd3 || busy !== 1'b1) begin errors++;
         $display("FAIL single_fields: pos=%0d data=%h type=%0d busy=%b want 5/a5/3/1", req_pos, req_data, req_type, busy); end
      rq_vld = '0;
      @(negedge clk);
      checks++; if (req_vld !== 1'b0 || rq_ack !== 4'b0000 || req_pos !== 8'd5) begin errors++;
         $display("FAIL single_issue_end: req_vld=%b rq_ack=%b pos=%0d want 0/0000/5", req_vld, rq_ack, req_pos); end
      give_resp(4'd2, 32'h77, 1'b1);
      checks++; if (rs_vld !== 4'b0100 || rs_data !== 32'h77 || rs_type !== 4'd2 || rs_data_vld !== 1'b1) begin errors++;
         $display("FAIL single_resp: rs_vld=%b data=%h type=%0d dv=%b want 0100/77/2/1", rs_vld, rs_data, rs_type, rs_data_vld); end
      checks++; if (resp_taken !== 1'b1) begin errors++;
         $display("FAIL single_resp_taken: got %b want 1", resp_taken); end
      @(negedge clk);
      checks++; if (resp_taken !== 1'b0 || rs_vld !== 4'b0100) begin errors++;
         $display("FAIL single_hold: resp_taken=%b rs_vld=%b want 0/0100", resp_taken, rs_vld); end
      take(2);
      checks++; if (rs_vld !== 4'b0000 || busy !== 1'b0) begin errors++;
         $display("FAIL single_take: rs_vld=%b busy=%b want 0000/0", rs_vld, busy); end
      // rr_ptr should now be 3: requester 3 beats requester 0.
      set_rq(0, 4'd1, 8'd10, 32'h10);
      set_rq(3, 4'd1, 8'd13, 32'h13);
      rq_vld = 4'b1001;
      wait_ack(got);
      checks++; if (!got || rq_ack !== 4'b1000) begin errors++;
         $display("FAIL single_rr_ptr: rq_ack=%b want 1000", rq_ack); end
      rq_vld = '0;
      @(negedge clk);
      give_resp(4'd1, 32'h0, 1'b0);
      take(3);
   endtask

   task automatic test_round_robin;
      logic got;
      int   order[5] = '{0, 1, 2, 3, 0};
      logic [N-1:0] exp;
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < N; i++) set_rq(i, 4'(i), 8'(i), 32'h100 + i);
      rq_vld = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         exp = 4'b0001 << order[k];
         wait_ack(got);
         checks++; if (!got || rq_ack !== exp || req_data !== 32'h100 + order[k]) begin errors++;
            $display("FAIL rr_grant%0d: rq_ack=%b data=%h want %b/%h", k, rq_ack, req_data, exp, 32'h100 + order[k]); end
         @(negedge clk);
         checks++; if (rq_ack !== 4'b0000) begin errors++;
            $display("FAIL rr_ack_width%0d: rq_ack=%b want 0000", k, rq_ack); end
         give_resp(4'd1, 32'h200 + k, 1'b1);
         take(order[k]);
         if (k == 4) rq_vld = '0;
      end
   endtask

   task automatic test_intf_ready;
      logic bad;
      bad = 1'b0;
      intf_ready = 1'b0;
      set_rq(0, 4'd7, 8'd44, 32'h4444);
      rq_vld = 4'b0001;
      repeat (10) begin
         @(negedge clk);
         if (req_vld !== 1'b0 || rq_ack !== 4'b0000) bad = 1'b1;
      end
      checks++; if (bad) begin errors++;
         $display("FAIL ready_low_grant: req_vld=%b rq_ack=%b want none while not ready", req_vld, rq_ack); end
      intf_ready = 1'b1;
      @(negedge clk);
      checks++; if (rq_ack !== 4'b0001 || req_vld !== 1'b1 || req_pos !== 8'd44) begin errors++;
         $display("FAIL ready_rise_grant: rq_ack=%b req_vld=%b pos=%0d want 0001/1/44", rq_ack, req_vld, req_pos); end
      rq_vld = '0;
      @(negedge clk);
      give_resp(4'd1, 32'h1, 1'b1);
      take(0);
   endtask

   task automatic test_timeout;
      logic got, bad;
      bad = 1'b0;
      set_rq(1, 4'd2, 8'd21, 32'h2121);
      rq_vld = 4'b0010;
      wait_ack(got);
      checks++; if (!got || rq_ack !== 4'b0010) begin errors++;
         $display("FAIL tmo_grant: rq_ack=%b want 0010", rq_ack); end
      rq_vld = '0;
      repeat (16) begin
         @(negedge clk);
         if (rs_vld !== 4'b0000 || timeout_err !== 1'b0) bad = 1'b1;
      end
      checks++; if (bad) begin errors++;
         $display("FAIL tmo_early: rs_vld=%b terr=%b before 16 wait cycles", rs_vld, timeout_err); end
      @(negedge clk);
      checks++; if (rs_vld !== 4'b0010 || rs_type !== 4'd0 || rs_data !== 32'hDEAD_0001 || rs_data_vld !== 1'b1) begin errors++;
         $display("FAIL tmo_resp: rs_vld=%b type=%0d data=%h dv=%b want 0010/0/dead0001/1", rs_vld, rs_type, rs_data, rs_data_vld); end
      checks++; if (timeout_err !== 1'b1 || resp_taken !== 1'b0) begin errors++;
         $display("FAIL tmo_flags: terr=%b resp_taken=%b want 1/0", timeout_err, resp_taken); end
      take(1);
      set_rq(0, 4'd3, 8'd9, 32'h0909);
      rq_vld = 4'b0001;
      wait_ack(got);
      checks++; if (!got || rq_ack !== 4'b0001 || req_data !== 32'h0909) begin errors++;
         $display("FAIL tmo_next_grant: rq_ack=%b data=%h want 0001/0909", rq_ack, req_data); end
      rq_vld = '0;
      @(negedge clk);
      give_resp(4'd6, 32'h1234, 1'b0);
      checks++; if (rs_vld !== 4'b0001 || rs_data !== 32'h1234 || rs_type !== 4'd6 || rs_data_vld !== 1'b0) begin errors++;
         $display("FAIL tmo_next_resp: rs_vld=%b data=%h type=%0d dv=%b want 0001/1234/6/0", rs_vld, rs_data, rs_type, rs_data_vld); end
      checks++; if (timeout_err !== 1'b1) begin errors++;
         $display("FAIL tmo_sticky: terr=%b want 1", timeout_err); end
      take(0);
   endtask

   task automatic test_slow_take;
      logic got, bad;
      bad = 1'b0;
      set_rq(0, 4'd1, 8'd1, 32'h0001);
      set_rq(1, 4'd1, 8'd2, 32'h0002);
      set_rq(2, 4'd1, 8'd3, 32'h0003);
      rq_vld = 4'b0001;
      wait_ack(got);
      checks++; if (!got || rq_ack !== 4'b0001) begin errors++;
         $display("FAIL slow_grant: rq_ack=%b want 0001", rq_ack); end
      rq_vld = 4'b0110;
      @(negedge clk);
      give_resp(4'd5, 32'hBEEF, 1'b1);
      for (int c = 0; c < 20; c++) begin
         rs_taken = (c == 5) ? 4'b0100 : 4'b0000;
         @(negedge clk);
         if (rs_vld !== 4'b0001 || rs_data !== 32'hBEEF || rs_type !== 4'd5 ||
             req_vld !== 1'b0 || rq_ack !== 4'b0000) bad = 1'b1;
      end
      rs_taken = '0;
      checks++; if (bad) begin errors++;
         $display("FAIL slow_hold: rs_vld=%b data=%h req_vld=%b rq_ack=%b want 0001/beef/0/0000 throughout", rs_vld, rs_data, req_vld, rq_ack); end
      take(0);
      checks++; if (rq_ack !== 4'b0000 || rs_vld !== 4'b0000) begin errors++;
         $display("FAIL slow_turnaround: rq_ack=%b rs_vld=%b want 0000/0000", rq_ack, rs_vld); end
      @(negedge clk);
      checks++; if (rq_ack !== 4'b0010 || req_data !== 32'h0002) begin errors++;
         $display("FAIL slow_next_grant: rq_ack=%b data=%h want 0010/0002", rq_ack, req_data); end
      rq_vld = '0;
      @(negedge clk);
      give_resp(4'd1, 32'h0, 1'b1);
      take(1);
   endtask

   task automatic test_async_reset;
      logic got;
      set_rq(3, 4'd9, 8'h33, 32'hCAFE_0003);
      rq_vld = 4'b1000;
      wait_ack(got);
      checks++; if (!got || rq_ack !== 4'b1000) begin errors++;
         $display("FAIL areset_grant: rq_ack=%b want 1000", rq_ack); end
      rq_vld = '0;
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || req_data !== 32'h0 || req_pos !== 8'h0 || timeout_err !== 1'b0 || rs_vld !== 4'b0000) begin errors++;
         $display("FAIL areset_outputs: busy=%b data=%h pos=%h terr=%b rs_vld=%b want all 0", busy, req_data, req_pos, timeout_err, rs_vld); end
      rq_vld = 4'b1001;
      @(negedge clk);
      reset_n = 1'b1;
      wait_ack(got);
      checks++; if (!got || rq_ack !== 4'b0001 || req_data !== 32'h0001) begin errors++;
         $display("FAIL areset_tie: rq_ack=%b data=%h want 0001/0001", rq_ack, req_data); end
      rq_vld = '0;
   endtask

   initial begin
      reset_n = 1'b0; rq_vld = '0; rq_type = '0; rq_pos = '0; rq_data = '0;
      rs_taken = '0; intf_ready = 1'b1; resp_vld = 1'b0; resp_type = '0;
      resp_data = '0; resp_data_vld = 1'b0;
      test_reset;
      test_single;
      test_round_robin;
      test_intf_ready;
      test_timeout;
      test_slow_take;
      test_async_reset;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
